// File: rtl/arch_pkg.sv
// arch_pkg: shared widths and hazard-controller state encoding
package arch_pkg;
  localparam int ADDR_W = 32;
  localparam int REG_AW = 4;
  typedef enum logic [1:0] {RUN = 2'd0, WAIT_MEM = 2'd1, FLUSH = 2'd2} state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: RAW compare of ID sources against EXE/MEM destinations
module hazard_detect #(
  parameter int REG_AW = arch_pkg::REG_AW
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              fwd_en,
  output logic              hazard
);
  logic exe_hit, mem_hit;
  assign exe_hit = exe_wb_en & (exe_dest == id_src1 | id_two_src & exe_dest == id_src2);
  assign mem_hit = mem_wb_en & (mem_dest == id_src1 | id_two_src & mem_dest == id_src2);
  // with forwarding only a load in EXE cannot be bypassed in time
  assign hazard = id_valid & (fwd_en ? exe_mem_r_en & exe_hit : exe_hit | mem_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: freeze/flush/redirect control for the fetch stage and IF/ID register
module pipeline_hazard_ctrl #(
  parameter int ADDR_W       = arch_pkg::ADDR_W,
  parameter int REG_AW       = arch_pkg::REG_AW,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              fwd_en,
  input  logic              exe_branch_taken,
  input  logic [ADDR_W-1:0] exe_branch_addr,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              freeze,
  output logic              flush,
  output logic              Branch_taken,
  output logic [ADDR_W-1:0] BranchAddr,
  output logic              mem_stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  import arch_pkg::*;
  localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] RELOAD = FW'(FLUSH_CYCLES - 1);
  state_t            state;
  logic [FW-1:0]     fcnt;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              hazard, issue;
  hazard_detect #(.REG_AW(REG_AW)) u_hd (
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .exe_dest    (exe_dest),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .fwd_en      (fwd_en),
    .hazard      (hazard)
  );
  assign mem_stall    = rst & mem_req & ~mem_ready;
  assign issue        = rst & (exe_branch_taken | pend_valid) & ~mem_stall;
  assign Branch_taken = issue;
  assign BranchAddr   = issue ? (pend_valid ? pend_addr : exe_branch_addr) : '0;
  // a redirect discards the instruction in ID, so its hazard no longer matters
  assign freeze       = mem_stall | (rst & hazard & ~issue);
  assign flush        = issue | (rst & state == FLUSH);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      fcnt       <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      if (issue) pend_valid <= 1'b0;
      else if (exe_branch_taken & mem_stall & ~pend_valid) begin
        pend_valid <= 1'b1;
        pend_addr  <= exe_branch_addr;
      end
      stall_cnt <= stall_cnt + CNT_W'(freeze & ~&stall_cnt);
      flush_cnt <= flush_cnt + CNT_W'(issue & ~&flush_cnt);
      if (issue && FLUSH_CYCLES > 1) begin
        state <= FLUSH;
        fcnt  <= RELOAD;
      end else begin
        case (state)
          RUN:      if (mem_stall) state <= WAIT_MEM;
          WAIT_MEM: if (!mem_stall) state <= RUN;
          FLUSH:    if (!mem_stall) begin
            if (fcnt == FW'(1)) state <= RUN;
            else fcnt <= fcnt - FW'(1);
          end
          default:  state <= RUN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of two controller builds against a reference model
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, id_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd_en;
  logic exe_branch_taken, mem_req, mem_ready;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic [31:0] exe_branch_addr;
  logic freeze1, flush1, bt1, ms1, freeze3, flush3, bt3, ms3;
  logic [31:0] ba1, ba3;
  logic [15:0] sc1, fc1;
  logic [3:0] sc3, fc3;
  int checks = 0, fails = 0;
  // reference model state
  int m_pv, fl1, fl3, m_sc1, m_fc1, m_sc3, m_fc3;
  logic [31:0] m_pa;
  logic e_stall, e_haz, e_issue, e_freeze, e_flush1, e_flush3;
  logic [31:0] e_ba;

  pipeline_hazard_ctrl u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .fwd_en(fwd_en), .exe_branch_taken(exe_branch_taken), .exe_branch_addr(exe_branch_addr),
    .mem_req(mem_req), .mem_ready(mem_ready), .freeze(freeze1), .flush(flush1),
    .Branch_taken(bt1), .BranchAddr(ba1), .mem_stall(ms1), .stall_cnt(sc1), .flush_cnt(fc1));

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .fwd_en(fwd_en), .exe_branch_taken(exe_branch_taken), .exe_branch_addr(exe_branch_addr),
    .mem_req(mem_req), .mem_ready(mem_ready), .freeze(freeze3), .flush(flush3),
    .Branch_taken(bt3), .BranchAddr(ba3), .mem_stall(ms3), .stall_cnt(sc3), .flush_cnt(fc3));

  task automatic model_eval();
    logic s1, s2;
    s1 = (exe_wb_en && exe_dest == id_src1) || (id_two_src && exe_wb_en && exe_dest == id_src2);
    s2 = (mem_wb_en && mem_dest == id_src1) || (id_two_src && mem_wb_en && mem_dest == id_src2);
    e_haz    = id_valid && (fwd_en ? (exe_mem_r_en && s1) : (s1 || s2));
    e_stall  = rst && mem_req && !mem_ready;
    e_issue  = rst && (exe_branch_taken || m_pv != 0) && !e_stall;
    e_ba     = !e_issue ? 32'h0 : (m_pv != 0 ? m_pa : exe_branch_addr);
    e_freeze = e_stall || (rst && e_haz && !e_issue);
    e_flush1 = rst && (e_issue || fl1 > 0);
    e_flush3 = rst && (e_issue || fl3 > 0);
  endtask

  // flush owes FLUSH_CYCLES-1 further unstalled cycles after each redirect
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (!rst) begin
      m_pv = 0; m_pa = 0; fl1 = 0; fl3 = 0; m_sc1 = 0; m_fc1 = 0; m_sc3 = 0; m_fc3 = 0;
    end else begin
      if (e_issue) m_pv = 0;
      else if (exe_branch_taken && e_stall && m_pv == 0) begin m_pv = 1; m_pa = exe_branch_addr; end
      fl1 = e_issue ? 0 : ((fl1 > 0 && !e_stall) ? fl1 - 1 : fl1);
      fl3 = e_issue ? 2 : ((fl3 > 0 && !e_stall) ? fl3 - 1 : fl3);
      if (e_freeze) begin
        if (m_sc1 < 65535) m_sc1++;
        if (m_sc3 < 15) m_sc3++;
      end
      if (e_issue) begin
        if (m_fc1 < 65535) m_fc1++;
        if (m_fc3 < 15) m_fc3++;
      end
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; exe_dest = 0; exe_wb_en = 0;
    exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0; fwd_en = 0; exe_branch_taken = 0;
    exe_branch_addr = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0; idle();
    id_valid = 1; exe_wb_en = 1; exe_branch_taken = 1; exe_branch_addr = 32'h1234; mem_req = 1;
    #1; checks++;
    if ({freeze1, flush1, bt1, ms1, ba1} !== 36'h0) begin fails++;
      $display("FAIL reset_comb: got %b%b%b%b %h want all zero", freeze1, flush1, bt1, ms1, ba1); end
    tick(); tick(); idle(); rst = 1; #1;
    checks++;
    if ({freeze1, flush1, bt1, ba1, sc1, fc1} !== 67'h0) begin fails++;
      $display("FAIL reset_state: got fr=%b fl=%b bt=%b ba=%h sc=%0d fc=%0d want zeros", freeze1, flush1, bt1, ba1, sc1, fc1); end
  endtask

  task automatic test_load_use();
    fwd_en = 1; id_valid = 1; id_src1 = 3; exe_dest = 3; exe_wb_en = 1; exe_mem_r_en = 1; #1;
    model_eval(); checks++;
    if (freeze1 !== 1'b1 || e_freeze !== 1'b1) begin fails++;
      $display("FAIL load_use_freeze: got %b model %b want 1", freeze1, e_freeze); end
    tick(); idle(); #1; checks++;
    if (sc1 !== 16'd1) begin fails++; $display("FAIL load_use_cnt: got %0d want 1", sc1); end
    fwd_en = 1; id_valid = 1; id_src1 = 3; exe_dest = 3; exe_wb_en = 1; exe_mem_r_en = 0; #1;
    checks++;
    if (freeze1 !== 1'b0) begin fails++; $display("FAIL fwd_no_load: got %b want 0", freeze1); end
    tick(); idle();
  endtask

  task automatic test_no_fwd();
    fwd_en = 0; id_valid = 1; id_src1 = 1; id_src2 = 5; id_two_src = 1; mem_dest = 5; mem_wb_en = 1;
    exe_dest = 7; exe_wb_en = 1; #1; checks++;
    if (freeze1 !== 1'b1) begin fails++; $display("FAIL nofwd_src2: got %b want 1", freeze1); end
    tick(); id_two_src = 0; #1; checks++;
    if (freeze1 !== 1'b0) begin fails++; $display("FAIL nofwd_one_src: got %b want 0", freeze1); end
    tick(); idle();
  endtask

  task automatic test_branch_hazard();
    fwd_en = 1; id_valid = 1; id_src1 = 3; exe_dest = 3; exe_wb_en = 1; exe_mem_r_en = 1;
    exe_branch_taken = 1; exe_branch_addr = 32'h20; #1; checks++;
    if ({bt1, flush1, freeze1} !== 3'b110 || ba1 !== 32'h20) begin fails++;
      $display("FAIL branch_hazard: got bt=%b fl=%b fr=%b ba=%h want 1 1 0 00000020", bt1, flush1, freeze1, ba1); end
    tick(); idle(); #1; checks++;
    if (fc1 !== 16'd1) begin fails++; $display("FAIL branch_cnt: got %0d want 1", fc1); end
  endtask

  task automatic test_branch_mem_stall();
    mem_req = 1; mem_ready = 0; exe_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      exe_branch_addr = (i == 0) ? 32'h40 : 32'h44; #1; checks++;
      if (freeze1 !== 1'b1 || bt1 !== 1'b0 || flush1 !== 1'b0) begin fails++;
        $display("FAIL stall_hold%0d: got fr=%b bt=%b fl=%b want 1 0 0", i, freeze1, bt1, flush1); end
      tick();
    end
    exe_branch_taken = 0; exe_branch_addr = 0; mem_ready = 1; #1; checks++;
    if (bt1 !== 1'b1 || ba1 !== 32'h40 || flush1 !== 1'b1) begin fails++;
      $display("FAIL pend_issue: got bt=%b ba=%h fl=%b want 1 00000040 1", bt1, ba1, flush1); end
    tick(); idle(); #1; checks++;
    if (bt1 !== 1'b0 || ba1 !== 32'h0) begin fails++;
      $display("FAIL pend_clear: got bt=%b ba=%h want 0 0", bt1, ba1); end
  endtask

  task automatic test_flush_stretch();
    logic [4:0] want = 5'b01111;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i == 0) begin exe_branch_taken = 1; exe_branch_addr = 32'h80; end
      if (i == 1) begin mem_req = 1; mem_ready = 0; end
      #1; model_eval(); checks++;
      if (flush3 !== want[i] || e_flush3 !== want[i]) begin fails++;
        $display("FAIL flush3_cyc%0d: got %b model %b want %b", i, flush3, e_flush3, want[i]); end
      tick();
    end
    idle(); exe_branch_taken = 1; exe_branch_addr = 32'h90; tick(); idle();
    rst = 0; #1; checks++;
    if (flush3 !== 1'b0) begin fails++; $display("FAIL flush3_rst_comb: got %b want 0", flush3); end
    tick(); rst = 1; #1; checks++;
    if (flush3 !== 1'b0 || fc3 !== 4'd0) begin fails++;
      $display("FAIL flush3_after_rst: got fl=%b fc=%0d want 0 0", flush3, fc3); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 49) != 0);
      id_valid = $urandom_range(0, 3) != 0; id_two_src = $urandom_range(0, 1);
      id_src1 = 4'($urandom_range(0, 3)); id_src2 = 4'($urandom_range(0, 3));
      exe_dest = 4'($urandom_range(0, 3)); mem_dest = 4'($urandom_range(0, 3));
      exe_wb_en = $urandom_range(0, 1); exe_mem_r_en = $urandom_range(0, 1);
      mem_wb_en = $urandom_range(0, 1); fwd_en = $urandom_range(0, 1);
      exe_branch_taken = $urandom_range(0, 5) == 0; exe_branch_addr = $urandom;
      mem_req = $urandom_range(0, 1); mem_ready = $urandom_range(0, 2) != 0;
      #1; model_eval(); checks++;
      if (freeze1 !== e_freeze || flush1 !== e_flush1 || bt1 !== e_issue || ba1 !== e_ba ||
          ms1 !== e_stall || sc1 !== 16'(m_sc1) || fc1 !== 16'(m_fc1)) begin fails++;
        $display("FAIL rand1_%0d: got fr=%b fl=%b bt=%b ba=%h ms=%b sc=%0d fc=%0d want %b %b %b %h %b %0d %0d",
          n, freeze1, flush1, bt1, ba1, ms1, sc1, fc1, e_freeze, e_flush1, e_issue, e_ba, e_stall, m_sc1, m_fc1); end
      checks++;
      if (freeze3 !== e_freeze || flush3 !== e_flush3 || bt3 !== e_issue || ba3 !== e_ba ||
          ms3 !== e_stall || sc3 !== 4'(m_sc3) || fc3 !== 4'(m_fc3)) begin fails++;
        $display("FAIL rand3_%0d: got fr=%b fl=%b bt=%b ba=%h ms=%b sc=%0d fc=%0d want %b %b %b %h %b %0d %0d",
          n, freeze3, flush3, bt3, ba3, ms3, sc3, fc3, e_freeze, e_flush3, e_issue, e_ba, e_stall, m_sc3, m_fc3); end
      tick();
    end
  endtask

  initial begin
    m_pv = 0; m_pa = 0; fl1 = 0; fl3 = 0; m_sc1 = 0; m_fc1 = 0; m_sc3 = 0; m_fc3 = 0;
    test_reset();
    test_load_use();
    test_no_fwd();
    test_branch_hazard();
    test_branch_mem_stall();
    test_flush_stretch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
